// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared constants and state encoding for the MCP3008-style SPI ADC emulator
package adc_spi_pkg;
  localparam int ADC_DATA_W     = 10;
  localparam int ADC_N_CH       = 8;
  localparam int ADC_CMD_BITS   = 4;
  localparam int ADC_NULL_FALLS = 2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_CMD,
    S_SAMPLE,
    S_NULL,
    S_DATA,
    S_TRAIL
  } adc_rsp_state_t;
  function automatic logic mid_frame(adc_rsp_state_t s);
    return s inside {S_CMD, S_SAMPLE, S_NULL, S_DATA};
  endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchroniser for one async SPI pin with rise/fall pulses
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  // shift the raw pin through the chain and remember the last synced level
  always_comb begin
    sync_d = STAGES'({sync_q, pin});
    prev_d = sync_q[STAGES-1];
  end
  // synchroniser and edge-detect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign lvl  = sync_q[STAGES-1];
  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;
endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: emulates an 8-channel 10-bit SPI ADC answering start/SGL/D2..D0 commands
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int N_CH        = ADC_N_CH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs_n,
  input  logic                   sclk,
  input  logic                   din,
  output logic                   dout,
  output logic                   dout_oe,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  output logic                   conv_valid,
  output logic [2:0]             conv_ch,
  output logic                   conv_sgl,
  output logic                   frame_abort,
  output logic                   busy
);
  localparam int CNT_W = $clog2(DATA_W);
  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic din_lvl, din_rise, din_fall;
  logic unused_edges;
  adc_rsp_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] cmd_q, cmd_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic dout_q, dout_d;
  logic conv_valid_q, conv_valid_d;
  logic [2:0] conv_ch_q, conv_ch_d;
  logic conv_sgl_q, conv_sgl_d;
  logic frame_abort_q, frame_abort_d;
  logic armed_q, armed_d;
  logic [2:0] cmd_ch;
  logic [DATA_W-1:0] ch_sel;
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst(rst), .pin(cs_n), .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst(rst), .pin(sclk), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_din (
    .clk(clk), .rst(rst), .pin(din), .lvl(din_lvl), .rise(din_rise), .fall(din_fall)
  );
  assign unused_edges = &{1'b0, cs_fall, sclk_lvl, din_rise, din_fall};
  assign cmd_ch = {cmd_q[1:0], din_lvl};
  // pick the channel addressed by the command bits sampled so far plus the live D0
  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < N_CH; i++)
      if (cmd_ch == 3'(i)) ch_sel = ch_data[DATA_W*i +: DATA_W];
  end
  // frame sequencing; a CS rise overrides any same-cycle sclk edge
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    shift_d       = shift_q;
    dout_d        = dout_q;
    conv_valid_d  = 1'b0;
    conv_ch_d     = conv_ch_q;
    conv_sgl_d    = conv_sgl_q;
    frame_abort_d = 1'b0;
    armed_d       = armed_q | cs_lvl;
    if (cs_rise) begin
      state_d       = S_IDLE;
      dout_d        = 1'b0;
      frame_abort_d = mid_frame(state_q);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (armed_q && !cs_lvl) begin
            state_d = S_WAIT_START;
            dout_d  = 1'b0;
          end
        end
        S_WAIT_START: begin
          if (sclk_rise && din_lvl) begin
            state_d = S_CMD;
            cnt_d   = '0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            cmd_d = {cmd_q[1:0], din_lvl};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ADC_CMD_BITS - 1)) begin
              state_d      = S_SAMPLE;
              shift_d      = ch_sel;
              conv_valid_d = 1'b1;
              conv_ch_d    = cmd_ch;
              conv_sgl_d   = cmd_q[2];
            end
          end
        end
        S_SAMPLE: begin
          if (sclk_fall) begin
            state_d = S_NULL;
            dout_d  = 1'b0;
          end
        end
        S_NULL: begin
          if (sclk_fall) begin
            state_d = S_DATA;
            dout_d  = 1'b0;
            cnt_d   = CNT_W'(DATA_W - 1);
          end
        end
        S_DATA: begin
          if (sclk_fall) begin
            dout_d  = shift_q[cnt_q];
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == '0) ? S_TRAIL : S_DATA;
          end
        end
        S_TRAIL: begin
          if (sclk_fall) dout_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // state, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cmd_q         <= '0;
      shift_q       <= '0;
      dout_q        <= 1'b0;
      conv_valid_q  <= 1'b0;
      conv_ch_q     <= '0;
      conv_sgl_q    <= 1'b0;
      frame_abort_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      shift_q       <= shift_d;
      dout_q        <= dout_d;
      conv_valid_q  <= conv_valid_d;
      conv_ch_q     <= conv_ch_d;
      conv_sgl_q    <= conv_sgl_d;
      frame_abort_q <= frame_abort_d;
      armed_q       <= armed_d;
    end
  end
  assign busy        = (state_q != S_IDLE);
  assign dout_oe     = busy;
  assign dout        = dout_q;
  assign conv_valid  = conv_valid_q;
  assign conv_ch     = conv_ch_q;
  assign conv_sgl    = conv_sgl_q;
  assign frame_abort = frame_abort_q;
endmodule
